// File: rtl/cofre_pkg.sv
// cofre_pkg: shared types and constants for the safe's password-programming block
package cofre_pkg;
  typedef enum logic [2:0] {OCIOSO, NOVA, REPETE, GRAVA, ERRO} estado_t;
  localparam int DIGITO_W = 4;
  localparam logic [DIGITO_W-1:0] DIGITO_MAX = 4'd9;
  localparam logic [15:0] SENHA_PADRAO = 16'h5103;
  localparam int TEMPO_W = 29;
  function automatic logic [15:0] grava_digito(input logic [15:0] w, input logic [1:0] i,
                                               input logic [DIGITO_W-1:0] d);
    logic [15:0] r;
    r = w;
    r[{i, 2'b00} +: DIGITO_W] = d;
    return r;
  endfunction
endpackage

// File: rtl/cofre_temporizador.sv
// cofre_temporizador: 29-bit cycle counter with clear, enable and terminal-count flag
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count (wins over en)
//   en         : advance the count by one
//   limite     : number of cycles to measure
//   fim        : high in the limite-th counted cycle after a clear
module cofre_temporizador
  import cofre_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic [TEMPO_W-1:0] limite,
  output logic               fim
);
  logic [TEMPO_W-1:0] count_q, count_d;
  always_comb begin
    count_d = clr ? '0 : en ? count_q + TEMPO_W'(1) : count_q;
    fim     = count_q >= limite - TEMPO_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end
endmodule

// File: rtl/cofre_programador.sv
// cofre_programador: writer of the safe's stored password; new code is entered twice and written on match
//   MAX10_CLK1_50 : 50 MHz clock
//   KEY1          : async active-low reset
//   habilita      : safe unlocked; low aborts any session (except ERRO)
//   iniciar       : pulse starting a session
//   confirma      : edge-detected pulse sampling digito_in
//   digito_in     : digit from SW[3:0]
//   senha         : stored password (digit0 in [3:0])
//   senha_wr      : one-cycle strobe while the new senha is presented
//   ocupado, erro : session in progress / dwelling in error state
//   n_digitos     : digits accepted in the current phase
//   fase          : 0 first entry, 1 repeat entry
// Build option COFRE_REJEITA_IGUAL_EN: reject a new code equal to the current one.
module cofre_programador
  import cofre_pkg::*;
#(
  parameter logic [15:0]        SENHA_PADRAO  = cofre_pkg::SENHA_PADRAO,
  parameter logic [TEMPO_W-1:0] TEMPO_TIMEOUT = 29'd500_000_000,
  parameter logic [TEMPO_W-1:0] TEMPO_ERRO    = 29'd150_000_000
) (
  input  logic                MAX10_CLK1_50,
  input  logic                KEY1,
  input  logic                habilita,
  input  logic                iniciar,
  input  logic                confirma,
  input  logic [DIGITO_W-1:0] digito_in,
  output logic [15:0]         senha,
  output logic                senha_wr,
  output logic                ocupado,
  output logic                erro,
  output logic [2:0]          n_digitos,
  output logic                fase
);
  estado_t estado_q, estado_d;
  logic [15:0] senha_q, senha_d, novo_q, novo_d, rep_q, rep_d, rep_full;
  logic [2:0] n_q, n_d;
  logic fase_q, fase_d, senha_wr_q, senha_wr_d, ocupado_q, ocupado_d, erro_q, erro_d;
  logic valido, ultimo, igual, fim, clr, en;
  logic [TEMPO_W-1:0] limite;
  // One timer serves both the entry timeout and the error dwell.
  cofre_temporizador u_tempo (
    .clk    (MAX10_CLK1_50),
    .rst_n  (KEY1),
    .clr    (clr),
    .en     (en),
    .limite (limite),
    .fim    (fim)
  );
  always_comb begin
    estado_d = estado_q;
    senha_d  = senha_q;
    novo_d   = novo_q;
    rep_d    = rep_q;
    n_d      = n_q;
    fase_d   = fase_q;
    valido   = confirma && (digito_in <= DIGITO_MAX);
    ultimo   = n_q == 3'd3;
    rep_full = grava_digito(rep_q, n_q[1:0], digito_in);
`ifdef COFRE_REJEITA_IGUAL_EN
    igual    = novo_q == senha_q;
`else
    igual    = 1'b0;
`endif
    // Any confirma (even an invalid digit) restarts the timeout; so does idling before NOVA.
    clr      = estado_q == OCIOSO || estado_q == GRAVA ||
               (confirma && (estado_q == NOVA || estado_q == REPETE));
    en       = estado_q != OCIOSO;
    limite   = estado_q == ERRO ? TEMPO_ERRO : TEMPO_TIMEOUT;
    case (estado_q)
      OCIOSO: if (iniciar && habilita) begin
        estado_d = NOVA;
        n_d      = '0;
        fase_d   = 1'b0;
        novo_d   = '0;
        rep_d    = '0;
      end
      NOVA:
        if (!habilita) estado_d = OCIOSO;
        else if (valido) begin
          novo_d   = grava_digito(novo_q, n_q[1:0], digito_in);
          n_d      = ultimo ? 3'd0 : n_q + 3'd1;
          estado_d = ultimo ? REPETE : NOVA;
          fase_d   = ultimo;
        end else if (!confirma && fim) estado_d = OCIOSO;
      REPETE:
        if (!habilita) estado_d = OCIOSO;
        else if (valido) begin
          rep_d = rep_full;
          n_d   = n_q + 3'd1;
          if (ultimo) begin
            estado_d = (rep_full == novo_q && !igual) ? GRAVA : ERRO;
            senha_d  = (rep_full == novo_q && !igual) ? novo_q : senha_q;
          end
        end else if (!confirma && fim) estado_d = OCIOSO;
      GRAVA:   estado_d = OCIOSO;
      ERRO:    estado_d = fim ? OCIOSO : ERRO;
      default: estado_d = OCIOSO;
    endcase
    senha_wr_d = estado_d == GRAVA;
    ocupado_d  = estado_d == NOVA || estado_d == REPETE || estado_d == GRAVA;
    erro_d     = estado_d == ERRO;
  end
  always_ff @(posedge MAX10_CLK1_50 or negedge KEY1) begin
    if (!KEY1) begin
      estado_q   <= OCIOSO;
      senha_q    <= SENHA_PADRAO;
      novo_q     <= '0;
      rep_q      <= '0;
      n_q        <= '0;
      fase_q     <= 1'b0;
      senha_wr_q <= 1'b0;
      ocupado_q  <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      senha_q    <= senha_d;
      novo_q     <= novo_d;
      rep_q      <= rep_d;
      n_q        <= n_d;
      fase_q     <= fase_d;
      senha_wr_q <= senha_wr_d;
      ocupado_q  <= ocupado_d;
      erro_q     <= erro_d;
    end
  end
  assign senha     = senha_q;
  assign senha_wr  = senha_wr_q;
  assign ocupado   = ocupado_q;
  assign erro      = erro_q;
  assign n_digitos = n_q;
  assign fase      = fase_q;
endmodule

// File: tb/tb_cofre_programador.sv
// tb_cofre_programador: directed self-checking bench for cofre_programador
module tb_cofre_programador;
  logic clk = 1'b0, rst_n = 1'b0, habilita = 1'b0, iniciar = 1'b0, confirma = 1'b0;
  logic [3:0] digito_in = 4'd0;
  logic [15:0] senha;
  logic senha_wr, ocupado, erro, fase;
  logic [2:0] n_digitos;
  int tests = 0, fails = 0, wr_pulses = 0, w0 = 0;
  always #5 clk = ~clk;
  always @(negedge clk) if (senha_wr) wr_pulses++;
  cofre_programador #(.TEMPO_TIMEOUT(29'd20), .TEMPO_ERRO(29'd5)) dut (
    .MAX10_CLK1_50 (clk),
    .KEY1          (rst_n),
    .habilita      (habilita),
    .iniciar       (iniciar),
    .confirma      (confirma),
    .digito_in     (digito_in),
    .senha         (senha),
    .senha_wr      (senha_wr),
    .ocupado       (ocupado),
    .erro          (erro),
    .n_digitos     (n_digitos),
    .fase          (fase)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic digito(input logic [3:0] d);
    digito_in = d;
    confirma = 1'b1;
    tick();
    confirma = 1'b0;
  endtask
  task automatic entra4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    digito(a);
    digito(b);
    digito(c);
    digito(d);
  endtask
  task automatic inicia();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask
  initial begin
    repeat (3) tick();
    check("rst_senha", senha, 16'h5103);
    check("rst_wr", 16'(senha_wr), 16'h0);
    check("rst_ocupado", 16'(ocupado), 16'h0);
    check("rst_erro", 16'(erro), 16'h0);
    check("rst_n_fase", {12'h0, fase, n_digitos}, 16'h0);
    rst_n = 1'b1;
    habilita = 1'b1;
    tick();
    inicia();
    check("mm_ocupado", 16'(ocupado), 16'h1);
    entra4(4'd1, 4'd1, 4'd1, 4'd1);
    check("mm_fase", 16'(fase), 16'h1);
    entra4(4'd1, 4'd1, 4'd1, 4'd2);
    check("mm_erro_c1", 16'(erro), 16'h1);
    check("mm_no_wr", 16'(senha_wr), 16'h0);
    repeat (4) tick();
    check("mm_erro_c5", 16'(erro), 16'h1);
    tick();
    check("mm_erro_end", 16'(erro), 16'h0);
    check("mm_senha", senha, 16'h5103);
    check("mm_pulses", 16'(wr_pulses), 16'h0);
    inicia();
    entra4(4'd7, 4'd2, 4'd9, 4'd4);
    digito(4'd7);
    digito(4'd2);
    digito(4'd9);
    check("ok_n3", 16'(n_digitos), 16'h3);
    w0 = wr_pulses;
    digito(4'd4);
    check("ok_wr", 16'(senha_wr), 16'h1);
    check("ok_senha", senha, 16'h4927);
    tick();
    check("ok_wr_end", 16'(senha_wr), 16'h0);
    check("ok_idle", 16'(ocupado), 16'h0);
    check("ok_pulses", 16'(wr_pulses - w0), 16'h1);
    inicia();
    digito(4'd12);
    check("inv12_n", 16'(n_digitos), 16'h0);
    digito(4'd10);
    check("inv10_n", 16'(n_digitos), 16'h0);
    check("inv_busy", 16'(ocupado), 16'h1);
    entra4(4'd8, 4'd8, 4'd8, 4'd8);
    check("inv_fase", {12'h0, fase, n_digitos}, 16'h8);
    w0 = wr_pulses;
    digito(4'd8);
    digito(4'd8);
    check("ab_n2", 16'(n_digitos), 16'h2);
    habilita = 1'b0;
    tick();
    check("ab_idle", 16'(ocupado), 16'h0);
    check("ab_senha", senha, 16'h4927);
    habilita = 1'b1;
    inicia();
    repeat (19) tick();
    check("to_busy19", 16'(ocupado), 16'h1);
    tick();
    check("to_idle20", 16'(ocupado), 16'h0);
    check("to_pulses", 16'(wr_pulses - w0), 16'h0);
    inicia();
    repeat (15) tick();
    digito(4'd12);
    repeat (19) tick();
    check("to_rst_busy", 16'(ocupado), 16'h1);
    tick();
    check("to_rst_idle", 16'(ocupado), 16'h0);
    inicia();
    digito_in = 4'd5;
    confirma = 1'b1;
    habilita = 1'b0;
    tick();
    confirma = 1'b0;
    check("ab_conf_idle", 16'(ocupado), 16'h0);
    check("ab_conf_senha", senha, 16'h4927);
    habilita = 1'b1;
    inicia();
    digito(4'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_senha", senha, 16'h5103);
    check("mid_rst_idle", 16'(ocupado), 16'h0);
    tick();
    rst_n = 1'b1;
    tick();
    inicia();
    entra4(4'd3, 4'd0, 4'd1, 4'd5);
    w0 = wr_pulses;
    entra4(4'd3, 4'd0, 4'd1, 4'd5);
`ifdef COFRE_REJEITA_IGUAL_EN
    check("eq_erro", 16'(erro), 16'h1);
    check("eq_wr", 16'(senha_wr), 16'h0);
`else
    check("eq_erro", 16'(erro), 16'h0);
    check("eq_wr", 16'(senha_wr), 16'h1);
`endif
    check("eq_senha", senha, 16'h5103);
    repeat (6) tick();
`ifdef COFRE_REJEITA_IGUAL_EN
    check("eq_pulses", 16'(wr_pulses - w0), 16'h0);
`else
    check("eq_pulses", 16'(wr_pulses - w0), 16'h1);
`endif
    check("end_idle", {14'h0, ocupado, erro}, 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
